// File: rtl/granule_splitter_if.sv
// granule_splitter_if: sample-stream input and paired-granule output bundle
interface granule_splitter_if #(parameter int WIDTH = 32);
  logic new_frame_start;
  logic valid_in;
  logic signed [WIDTH-1:0] ch1_in;
  logic signed [WIDTH-1:0] ch2_in;
  logic signed [WIDTH-1:0] gr1_ch1_out;
  logic signed [WIDTH-1:0] gr1_ch2_out;
  logic signed [WIDTH-1:0] gr2_ch1_out;
  logic signed [WIDTH-1:0] gr2_ch2_out;
  logic valid_out;
  logic frame_done;
  modport master(
    output new_frame_start, valid_in, ch1_in, ch2_in,
    input gr1_ch1_out, gr1_ch2_out, gr2_ch1_out, gr2_ch2_out, valid_out, frame_done
  );
  modport slave(
    input new_frame_start, valid_in, ch1_in, ch2_in,
    output gr1_ch1_out, gr1_ch2_out, gr2_ch1_out, gr2_ch2_out, valid_out, frame_done
  );
endinterface

// File: rtl/granule_splitter.sv
// granule_splitter: buffers granule 1, then emits it paired with incoming granule 2
module granule_splitter #(
  parameter int GR_SAMPLES = 576,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  granule_splitter_if.slave bus
);
  typedef enum logic [1:0] {FILL, PAIR, DONE} state_t;
  state_t state, state_n;
  logic [9:0] cnt, cnt_n;
  logic clr, wr, rd, last;
  logic [2*WIDTH-1:0] mem [GR_SAMPLES];
  logic [2*WIDTH-1:0] rd1, rd2, d1, d2;
  logic v1, v2;
  // next state, counter and port enables; a restart wins over a coincident sample
  always_comb begin
    clr = rst | bus.new_frame_start;
    last = cnt == 10'(GR_SAMPLES - 1);
    wr = !clr && bus.valid_in && state == FILL;
    rd = !clr && bus.valid_in && state == PAIR;
    state_n = clr ? FILL : ((wr || rd) && last) ? (state == FILL ? PAIR : DONE) : state;
    cnt_n = (clr || ((wr || rd) && last)) ? '0 : (wr || rd) ? cnt + 10'd1 : cnt;
  end
  // state and address counter registers
  always_ff @(posedge clk) begin
    state <= state_n;
    cnt <= cnt_n;
  end
  // granule-1 buffer with a two-register read path
  always_ff @(posedge clk) begin
    if (wr) mem[cnt] <= {bus.ch1_in, bus.ch2_in};
    rd1 <= mem[cnt];
    rd2 <= rd1;
  end
  // granule-2 delay pipe aligned with the buffer read latency
  always_ff @(posedge clk) begin
    v1 <= clr ? 1'b0 : rd;
    v2 <= clr ? 1'b0 : v1;
    d1 <= {bus.ch1_in, bus.ch2_in};
    d2 <= d1;
  end
  // output stage; data is forced to zero whenever no pair is presented
  always_comb begin
    bus.valid_out = v2;
    bus.gr1_ch1_out = v2 ? rd2[2*WIDTH-1 -: WIDTH] : '0;
    bus.gr1_ch2_out = v2 ? rd2[WIDTH-1:0] : '0;
    bus.gr2_ch1_out = v2 ? d2[2*WIDTH-1 -: WIDTH] : '0;
    bus.gr2_ch2_out = v2 ? d2[WIDTH-1:0] : '0;
    bus.frame_done = state == DONE && !v1 && !v2;
  end
endmodule

// File: tb/tb_granule_splitter.sv
// tb_granule_splitter: randomized scoreboard bench against a frame-level model
module tb_granule_splitter;
  localparam int GR = 576;
  localparam int BIG = 1 << 30;
  typedef struct {
    int due;
    logic [31:0] a, b, c, d;
  } pair_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  bit mon_on = 1'b0;
  pair_t exp_q[$];
  pair_t ent;
  logic [63:0] g1[$];
  int n = 0;
  int done_from = BIG;
  int done_to = BIG;
  granule_splitter_if #(.WIDTH(32)) bus();
  granule_splitter #(.GR_SAMPLES(GR), .WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endtask
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    if (n < GR) g1.push_back({a, b});
    else if (n < 2 * GR) begin
      p.due = cyc + 2;
      p.a = g1[n-GR][63:32];
      p.b = g1[n-GR][31:0];
      p.c = a;
      p.d = b;
      exp_q.push_back(p);
      if (n == 2 * GR - 1) begin
        done_from = cyc + 3;
        done_to = BIG;
      end
    end
    if (n < 2 * GR) n++;
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic nf, input logic r);
    bus.valid_in = v;
    bus.ch1_in = a;
    bus.ch2_in = b;
    bus.new_frame_start = nf;
    rst = r;
    if (r || nf) begin
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
      if (done_to > cyc) done_to = cyc;
      g1.delete();
      n = 0;
    end else if (v) accept(a, b);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic frame(input int cnt, input int base, input int mode);
    for (int i = 0; i < cnt; i++) begin
      if (mode == 2) begin
        while ($urandom_range(0, 2) == 0) idle(1);
        step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      end else begin
        step(1'b1, i + base, -(i + base), 1'b0, 1'b0);
        if (mode == 1) idle(2);
      end
    end
  endtask
  task automatic restart();
    step(1'b0, 0, 0, 1'b1, 1'b0);
  endtask
  // monitor: pops the scoreboard on every presented pair and checks idle cycles
  always @(negedge clk) begin
    if (mon_on) begin
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, cyc >= done_from && cyc <= done_to});
      if (bus.valid_out) begin
        chk("valid_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          chk("latency", cyc, ent.due);
          chk("gr1_ch1", bus.gr1_ch1_out, ent.a);
          chk("gr1_ch2", bus.gr1_ch2_out, ent.b);
          chk("gr2_ch1", bus.gr2_ch1_out, ent.c);
          chk("gr2_ch2", bus.gr2_ch2_out, ent.d);
        end
      end else begin
        chk("idle_data", bus.gr1_ch1_out | bus.gr1_ch2_out | bus.gr2_ch1_out | bus.gr2_ch2_out, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          ent = exp_q.pop_front();
          chk("missing_valid", {31'd0, bus.valid_out}, 32'd1);
        end
      end
    end
  end
  initial begin
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    mon_on = 1'b1;
    idle(3);
    frame(2 * GR, 0, 0);
    idle(8);
    restart();
    frame(2 * GR, 0, 1);
    idle(8);
    restart();
    frame(1200, 0, 0);
    idle(8);
    restart();
    frame(GR + 101, 0, 0);
    restart();
    frame(2 * GR, 5000, 0);
    idle(8);
    restart();
    frame(300, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    frame(2 * GR, 10000, 0);
    idle(8);
    step(1'b1, 7, 7, 1'b1, 1'b0);
    frame(2 * GR, 100, 0);
    idle(8);
    restart();
    frame(2 * GR, 0, 2);
    idle(8);
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
